deser_frame: RTL and testbench

//  Serial-to-parallel frame receiver that feeds the N-bit enable register stage downstream.

---
 rtl/deser_frame_if.sv | 24 ++
 rtl/deser_frame.sv | 109 ++++++++++
 tb/tb_deser_frame.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/deser_frame_if.sv
// Serial frame receiver bus: qualified serial input toward the receiver,
// assembled word, load strobe and status back toward the consumer.
interface deser_frame_if #(
    parameter int N = 8
);
    logic         sin;
    logic         sin_vld;
    logic [N-1:0] z;
    logic         en;
    logic         busy;
    logic         ferr;

    // master: serial source / word consumer side
    modport master (
        output sin, sin_vld,
        input  z, en, busy, ferr
    );

    // slave: the deserializer itself
    modport slave (
        input  sin, sin_vld,
        output z, en, busy, ferr
    );
endinterface

// File: rtl/deser_frame.sv
// Serial-to-parallel frame receiver: start bit, N data bits LSB first, stop bit.
// Define DESER_PARITY_EN to add a parity bit between data and stop (sense set by PAR_ODD).
module deser_frame #(
    parameter int N       = 8,
    parameter bit PAR_ODD = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    deser_frame_if.slave bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

`ifdef DESER_PARITY_EN
    typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_e;
`else
    typedef enum logic [1:0] {IDLE, DATA, STOP} state_e;
`endif

    state_e        state_q, state_d;
    logic [N-1:0]  sh_q, sh_d;
    logic [N-1:0]  z_q, z_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          en_q, en_d;
    logic          ferr_q, ferr_d;
    logic          perr_q, perr_d;

`ifndef DESER_PARITY_EN
    logic unused_par_odd;
    assign unused_par_odd = PAR_ODD;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
        end
    end

    // en_d defaults low so the strobe can never last past one cycle.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        z_d     = z_q;
        cnt_d   = cnt_q;
        en_d    = 1'b0;
        ferr_d  = ferr_q;
        perr_d  = perr_q;

        if (bus.sin_vld) begin
            case (state_q)
                IDLE: begin
                    if (!bus.sin) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        ferr_d  = 1'b0;
                        perr_d  = 1'b0;
                    end
                end
                DATA: begin
                    sh_d = {bus.sin, sh_q[N-1:1]};
                    if (cnt_q == CW'(N - 1)) begin
`ifdef DESER_PARITY_EN
                        state_d = PAR;
`else
                        state_d = STOP;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
`ifdef DESER_PARITY_EN
                PAR: begin
                    if (bus.sin != ((^sh_q) ^ PAR_ODD))
                        perr_d = 1'b1;
                    state_d = STOP;
                end
`endif
                STOP: begin
                    if (bus.sin && !perr_q) begin
                        z_d  = sh_q;
                        en_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.z    = z_q;
    assign bus.en   = en_q;
    assign bus.busy = (state_q != IDLE);
    assign bus.ferr = ferr_q;
endmodule

// File: tb/tb_deser_frame.sv
// Directed bench for deser_frame: stimulus pushes expected words, a negedge
// monitor pops and compares them whenever en is seen.
module tb_deser_frame;
    localparam int N = 8;
`ifdef DESER_PARITY_EN
    localparam int FRAME_LEN = N + 3;
`else
    localparam int FRAME_LEN = N + 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    deser_frame_if #(.N(N)) bus ();

    deser_frame #(.N(N), .PAR_ODD(1'b0)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // downstream enable register
    logic [N-1:0] dreg;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) dreg <= '0;
        else if (bus.en) dreg <= bus.z;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [N-1:0] exp_q[$];
    int en_cnt = 0;
    int en_cyc_last = 0;
    int en_cyc_prev = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor
    initial begin
        logic         prev_en;
        logic         dreg_pend;
        logic [N-1:0] last_exp;
        prev_en   = 1'b0;
        dreg_pend = 1'b0;
        last_exp  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_en   = 1'b0;
                dreg_pend = 1'b0;
            end else begin
                if (dreg_pend) begin
                    chk("dreg_load", 32'(dreg), 32'(last_exp));
                    dreg_pend = 1'b0;
                end
                if (bus.en) begin
                    if (prev_en) chk("en_consecutive", 32'(prev_en), 32'd0);
                    if (exp_q.size() == 0) begin
                        chk("en_unexpected", 32'(bus.en), 32'd0);
                    end else begin
                        last_exp = exp_q.pop_front();
                        chk("z_word", 32'(bus.z), 32'(last_exp));
                        dreg_pend = 1'b1;
                    end
                    en_cnt++;
                    en_cyc_prev = en_cyc_last;
                    en_cyc_last = cyc;
                end
                prev_en = bus.en;
            end
        end
    end

    // one clock edge with the given serial input; returns 1 time unit after it
    task automatic drive(input logic b, input logic v);
        bus.sin     = b;
        bus.sin_vld = v;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [N-1:0] data, input logic par,
                              input logic stop, input logic stall);
        drive(1'b0, 1'b1);
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        chk("ferr_clr_on_start", 32'(bus.ferr), 32'd0);
        if (stall) begin
            drive(1'b1, 1'b0);
            chk("busy_stall", 32'(bus.busy), 32'd1);
        end
        for (int i = 0; i < N; i++) begin
            drive(data[i], 1'b1);
            if (stall) begin
                drive(~data[i], 1'b0);
                chk("busy_stall", 32'(bus.busy), 32'd1);
            end
        end
`ifdef DESER_PARITY_EN
        drive(par, 1'b1);
        if (stall) begin
            drive(~par, 1'b0);
            chk("busy_stall", 32'(bus.busy), 32'd1);
        end
`else
        if (par === 1'bx) $display("note: parity arg unused");
`endif
        drive(stop, 1'b1);
        bus.sin     = 1'b1;
        bus.sin_vld = 1'b0;
    endtask

    initial begin
        int en0;
        bus.sin     = 1'b1;
        bus.sin_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_z", 32'(bus.z), 32'd0);
        chk("rst_en", 32'(bus.en), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ferr", 32'(bus.ferr), 32'd0);
        rst_n = 1'b1;
        drive(1'b1, 1'b0);

        // 1: abort after start + 3 data bits, then a clean 0x3C
        en0 = en_cnt;
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        chk("busy_mid_frame", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        bus.sin_vld = 1'b0;
        #2;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_z", 32'(bus.z), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 1'b0);
        chk("abort_no_en", 32'(en_cnt - en0), 32'd0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        chk("t1_en_count", 32'(en_cnt - en0), 32'd1);
        chk("t1_z", 32'(bus.z), 32'h3C);

        // 2: 0x4A, sin_vld every cycle
        en0 = en_cnt;
        exp_q.push_back(8'h4A);
        send_frame(8'h4A, 1'b1, 1'b1, 1'b0);
        chk("t2_en_after_stop", 32'(bus.en), 32'd1);
        drive(1'b1, 1'b0);
        chk("t2_en_drop", 32'(bus.en), 32'd0);
        chk("t2_dreg", 32'(dreg), 32'h4A);
        drive(1'b1, 1'b0);
        chk("t2_en_count", 32'(en_cnt - en0), 32'd1);

        // 3: same word, sin_vld toggling
        en0 = en_cnt;
        exp_q.push_back(8'h4A);
        send_frame(8'h4A, 1'b1, 1'b1, 1'b1);
        chk("t3_en_after_stop", 32'(bus.en), 32'd1);
        drive(1'b1, 1'b0);
        chk("t3_en_drop", 32'(bus.en), 32'd0);
        drive(1'b1, 1'b0);
        chk("t3_en_count", 32'(en_cnt - en0), 32'd1);

        // 4: bad stop bit on 0xFF
        en0 = en_cnt;
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
        chk("t4_ferr", 32'(bus.ferr), 32'd1);
        chk("t4_no_en", 32'(bus.en), 32'd0);
        chk("t4_z_hold", 32'(bus.z), 32'h4A);
        chk("t4_idle", 32'(bus.busy), 32'd0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        chk("t4_ferr_sticky", 32'(bus.ferr), 32'd1);
        chk("t4_en_count", 32'(en_cnt - en0), 32'd0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0);

        // 5: back-to-back 0x01, 0x80
        en0 = en_cnt;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h80);
        send_frame(8'h01, 1'b1, 1'b1, 1'b0);
        chk("t5_z_first", 32'(bus.z), 32'h01);
        send_frame(8'h80, 1'b1, 1'b1, 1'b0);
        chk("t5_z_second", 32'(bus.z), 32'h80);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        chk("t5_en_count", 32'(en_cnt - en0), 32'd2);
        chk("t5_en_gap", 32'(en_cyc_last - en_cyc_prev), 32'(FRAME_LEN));

`ifdef DESER_PARITY_EN
        // 6: parity, even sense
        en0 = en_cnt;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        chk("t6_good_en", 32'(bus.en), 32'd1);
        drive(1'b1, 1'b0);
        send_frame(8'h07, 1'b0, 1'b1, 1'b0);
        chk("t6_bad_ferr", 32'(bus.ferr), 32'd1);
        chk("t6_bad_no_en", 32'(bus.en), 32'd0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        chk("t6_en_count", 32'(en_cnt - en0), 32'd1);
        chk("t6_z", 32'(bus.z), 32'h07);
`endif

        repeat (4) drive(1'b1, 1'b0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
